// File: rtl/three_of_five_voter_if.sv
// Signal bundle for three_of_five_voter; the fault field exists only when
// THREE_OF_FIVE_FAULT_EN is defined.
interface three_of_five_voter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             valid_in;
  logic             in_1;
  logic             in_2;
  logic             in_3;
  logic             in_4;
  logic             in_5;
  logic             out;
  logic             valid_out;
  logic [2:0]       count;
  logic             unanimous;
  logic [4:0]       dissent;
  logic [CNT_W-1:0] dissent_cnt;
`ifdef THREE_OF_FIVE_FAULT_EN
  logic [4:0]       fault;
`endif

  modport master (
    output valid_in, in_1, in_2, in_3, in_4, in_5,
    input  out, valid_out, count, unanimous, dissent, dissent_cnt
`ifdef THREE_OF_FIVE_FAULT_EN
    , fault
`endif
  );

  modport slave (
    input  valid_in, in_1, in_2, in_3, in_4, in_5,
    output out, valid_out, count, unanimous, dissent, dissent_cnt
`ifdef THREE_OF_FIVE_FAULT_EN
    , fault
`endif
  );
endinterface

// File: rtl/three_of_five_voter.sv
// Registered 5-input threshold voter with pop-count, unanimity, dissent mask and
// saturating dissent counter. Define THREE_OF_FIVE_FAULT_EN for sticky per-input fault flags.
module three_of_five_voter #(
  parameter int unsigned THRESHOLD   = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FAULT_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst,
  three_of_five_voter_if.slave  bus
);

  if (THRESHOLD < 1 || THRESHOLD > 5) begin : g_bad_threshold
    $fatal(1, "three_of_five_voter: THRESHOLD must be in 1..5");
  end

  localparam logic [2:0] THR = 3'(THRESHOLD);

  logic [4:0]       samp;
  logic [2:0]       pc;
  logic             vote;
  logic [4:0]       dis;

  logic             out_q;
  logic             valid_q;
  logic [2:0]       count_q;
  logic             unan_q;
  logic [4:0]       dissent_q;
  logic [CNT_W-1:0] dcnt_q;

  assign samp = {bus.in_5, bus.in_4, bus.in_3, bus.in_2, bus.in_1};

  always_comb begin
    pc   = 3'(samp[0]) + 3'(samp[1]) + 3'(samp[2]) + 3'(samp[3]) + 3'(samp[4]);
    vote = (pc >= THR);
    dis  = samp ^ {5{vote}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      unan_q    <= 1'b0;
      dissent_q <= '0;
      dcnt_q    <= '0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        out_q     <= vote;
        count_q   <= pc;
        unan_q    <= (pc == 3'd0) || (pc == 3'd5);
        dissent_q <= dis;
        // Saturate at all-ones instead of wrapping.
        if ((|dis) && (dcnt_q != '1)) begin
          dcnt_q <= dcnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.valid_out   = valid_q;
  assign bus.count       = count_q;
  assign bus.unanimous   = unan_q;
  assign bus.dissent     = dissent_q;
  assign bus.dissent_cnt = dcnt_q;

`ifdef THREE_OF_FIVE_FAULT_EN
  localparam int unsigned FW = $clog2(FAULT_LIMIT + 1);
  localparam logic [FW-1:0] FL   = FW'(FAULT_LIMIT);
  localparam logic [FW-1:0] FLM1 = FW'(FAULT_LIMIT - 1);

  logic [FW-1:0] fcnt [5];
  logic [4:0]    fault_q;

  // Fault sets on the same edge the run length reaches FAULT_LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 5; k++) begin
        fcnt[k] <= '0;
      end
      fault_q <= '0;
    end else if (bus.valid_in) begin
      for (int unsigned k = 0; k < 5; k++) begin
        if (dis[k]) begin
          if (fcnt[k] != FL) begin
            fcnt[k] <= fcnt[k] + 1'b1;
          end
          if (fcnt[k] >= FLM1) begin
            fault_q[k] <= 1'b1;
          end
        end else begin
          fcnt[k] <= '0;
        end
      end
    end
  end

  assign bus.fault = fault_q;
`endif

endmodule

// File: tb/tb_three_of_five_voter.sv
// Scoreboard bench for three_of_five_voter: four instances (T=3, T=3/CNT_W=2, T=5, T=1)
// share one stimulus stream; expected results are queued on drive and popped on output.
module tb_three_of_five_voter;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [4:0] ins;

  three_of_five_voter_if #(.CNT_W(16)) b3 ();
  three_of_five_voter_if #(.CNT_W(2))  b_sat ();
  three_of_five_voter_if #(.CNT_W(16)) b5 ();
  three_of_five_voter_if #(.CNT_W(16)) b1 ();

  assign b3.valid_in    = valid;
  assign b_sat.valid_in = valid;
  assign b5.valid_in    = valid;
  assign b1.valid_in    = valid;
  assign {b3.in_5, b3.in_4, b3.in_3, b3.in_2, b3.in_1}                = ins;
  assign {b_sat.in_5, b_sat.in_4, b_sat.in_3, b_sat.in_2, b_sat.in_1} = ins;
  assign {b5.in_5, b5.in_4, b5.in_3, b5.in_2, b5.in_1}                = ins;
  assign {b1.in_5, b1.in_4, b1.in_3, b1.in_2, b1.in_1}                = ins;

  three_of_five_voter #(.THRESHOLD(3), .CNT_W(16), .FAULT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .bus(b3));
  three_of_five_voter #(.THRESHOLD(3), .CNT_W(2), .FAULT_LIMIT(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(b_sat));
  three_of_five_voter #(.THRESHOLD(5), .CNT_W(16), .FAULT_LIMIT(4)) dut_t5 (
    .clk(clk), .rst(rst), .bus(b5));
  three_of_five_voter #(.THRESHOLD(1), .CNT_W(16), .FAULT_LIMIT(4)) dut_t1 (
    .clk(clk), .rst(rst), .bus(b1));

  typedef struct packed {
    logic        out;
    logic [2:0]  count;
    logic        unan;
    logic [4:0]  dissent;
    logic [15:0] dcnt;
  } res_t;
  typedef res_t [3:0] res4_t;

  res4_t       q[$];
  res_t        m[4];
  int unsigned thr[4]  = '{3, 3, 5, 1};
  int unsigned cmax[4] = '{65535, 3, 65535, 65535};
  int          checks = 0;
  int          errors = 0;
`ifdef THREE_OF_FIVE_FAULT_EN
  int unsigned fcnt_m[5];
  logic [4:0]  fault_m;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t actual(input int d);
    res_t r;
    case (d)
      0: r = {b3.out, b3.count, b3.unanimous, b3.dissent, b3.dissent_cnt};
      1: r = {b_sat.out, b_sat.count, b_sat.unanimous, b_sat.dissent, 14'd0, b_sat.dissent_cnt};
      2: r = {b5.out, b5.count, b5.unanimous, b5.dissent, b5.dissent_cnt};
      default: r = {b1.out, b1.count, b1.unanimous, b1.dissent, b1.dissent_cnt};
    endcase
    return r;
  endfunction

  function automatic logic vout(input int d);
    case (d)
      0: return b3.valid_out;
      1: return b_sat.valid_out;
      2: return b5.valid_out;
      default: return b1.valid_out;
    endcase
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 4; d++) m[d] = '0;
    q.delete();
`ifdef THREE_OF_FIVE_FAULT_EN
    for (int k = 0; k < 5; k++) fcnt_m[k] = 0;
    fault_m = '0;
`endif
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (vout(d) !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d valid_out got %b expected 0", name, d, vout(d));
      end
      checks++;
      if (actual(d) !== res_t'(0)) begin
        errors++;
        $display("FAIL %s dut%0d outputs got %h expected 0", name, d, actual(d));
      end
    end
`ifdef THREE_OF_FIVE_FAULT_EN
    checks++;
    if (b3.fault !== 5'b0) begin
      errors++;
      $display("FAIL %s fault got %b expected 00000", name, b3.fault);
    end
`endif
  endtask

  // Drive one sample at a negedge, let one rising edge pass, compare at the next negedge.
  task automatic step(input string name, input logic v, input logic [4:0] p);
    res4_t       e;
    int unsigned pc;
    logic        vote;
    res_t        a;
    valid = v;
    ins   = p;
    if (v) begin
      pc = $countones(p);
      for (int d = 0; d < 4; d++) begin
        vote         = (pc >= thr[d]);
        m[d].out     = vote;
        m[d].count   = 3'(pc);
        m[d].unan    = (pc == 0) || (pc == 5);
        m[d].dissent = p ^ {5{vote}};
        if (m[d].dissent != 5'b0 && m[d].dcnt < 16'(cmax[d])) m[d].dcnt = m[d].dcnt + 16'd1;
        e[d] = m[d];
      end
`ifdef THREE_OF_FIVE_FAULT_EN
      for (int k = 0; k < 5; k++) begin
        if (m[0].dissent[k]) begin
          fcnt_m[k]++;
          if (fcnt_m[k] >= 4) fault_m[k] = 1'b1;
        end else begin
          fcnt_m[k] = 0;
        end
      end
`endif
      q.push_back(e);
    end
    @(negedge clk);
    if (v) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard empty got 0 entries expected 1", name);
        for (int d = 0; d < 4; d++) e[d] = m[d];
      end else begin
        e = q.pop_front();
      end
    end else begin
      for (int d = 0; d < 4; d++) e[d] = m[d];
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (vout(d) !== v) begin
        errors++;
        $display("FAIL %s dut%0d valid_out got %b expected %b", name, d, vout(d), v);
      end
      a = actual(d);
      checks++;
      if (a !== e[d]) begin
        errors++;
        $display("FAIL %s dut%0d in=%b got out=%b cnt=%0d un=%b dis=%b dc=%0d expected out=%b cnt=%0d un=%b dis=%b dc=%0d",
                 name, d, p, a.out, a.count, a.unan, a.dissent, a.dcnt,
                 e[d].out, e[d].count, e[d].unan, e[d].dissent, e[d].dcnt);
      end
    end
`ifdef THREE_OF_FIVE_FAULT_EN
    checks++;
    if (b3.fault !== fault_m) begin
      errors++;
      $display("FAIL %s fault got %b expected %b", name, b3.fault, fault_m);
    end
`endif
  endtask

  // Pulse reset between clock edges and confirm outputs clear without a clock.
  task automatic do_reset(input string name);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero(name);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 7; i++) step("preload", 1'b1, 5'b11100);
    checks++;
    if (b3.out !== 1'b1 || b3.dissent_cnt !== 16'd7) begin
      errors++;
      $display("FAIL reset_preload got out=%b dc=%0d expected out=1 dc=7", b3.out, b3.dissent_cnt);
    end
    #2 rst = 1'b1;
    #1 check_zero("reset_async");
    valid = 1'b1;
    ins   = 5'b11111;
    @(posedge clk);
    #1 check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    step("after_reset", 1'b1, 5'b10110);
  endtask

  task automatic test_exhaustive();
    for (int p = 0; p < 32; p++) step("exhaustive", 1'b1, 5'(p));
    step("ex_10110", 1'b1, 5'b10110);
    checks++;
    if (b3.count !== 3'd3 || b3.out !== 1'b1 || b3.dissent !== 5'b01001) begin
      errors++;
      $display("FAIL ex_10110 got cnt=%0d out=%b dis=%b expected cnt=3 out=1 dis=01001",
               b3.count, b3.out, b3.dissent);
    end
    step("ex_10010", 1'b1, 5'b10010);
    checks++;
    if (b3.count !== 3'd2 || b3.out !== 1'b0) begin
      errors++;
      $display("FAIL ex_10010 got cnt=%0d out=%b expected cnt=2 out=0", b3.count, b3.out);
    end
  endtask

  task automatic test_hold();
    step("hold_zero", 1'b1, 5'b00000);
    step("hold_idle", 1'b0, 5'b11111);
    step("hold_idle2", 1'b0, 5'b10101);
    step("hold_next", 1'b1, 5'b11111);
    checks++;
    if (b3.out !== 1'b1 || b3.count !== 3'd5 || b3.unanimous !== 1'b1) begin
      errors++;
      $display("FAIL hold_next got out=%b cnt=%0d un=%b expected out=1 cnt=5 un=1",
               b3.out, b3.count, b3.unanimous);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] tab [5];
    tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset("sat_reset");
    for (int i = 0; i < 5; i++) begin
      step("sat", 1'b1, 5'b11100);
      checks++;
      if (b_sat.dissent_cnt !== tab[i]) begin
        errors++;
        $display("FAIL sat_seq%0d got %0d expected %0d", i, b_sat.dissent_cnt, tab[i]);
      end
    end
    step("sat_unan", 1'b1, 5'b11111);
    checks++;
    if (b_sat.dissent_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_unan got %0d expected 3", b_sat.dissent_cnt);
    end
  endtask

  task automatic test_parameter();
    step("param_t5", 1'b1, 5'b11110);
    checks++;
    if (b5.out !== 1'b0 || b5.dissent !== 5'b11110) begin
      errors++;
      $display("FAIL param_t5 got out=%b dis=%b expected out=0 dis=11110", b5.out, b5.dissent);
    end
    step("param_t1", 1'b1, 5'b00001);
    checks++;
    if (b1.out !== 1'b1) begin
      errors++;
      $display("FAIL param_t1 got out=%b expected 1", b1.out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      step("b2b", ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
    end
    valid = 1'b0;
  endtask

`ifdef THREE_OF_FIVE_FAULT_EN
  task automatic test_fault();
    logic [4:0] seq [11];
    seq = '{5'b11101, 5'b11101, 5'b11101, 5'b11111, 5'b11101, 5'b11101,
            5'b11101, 5'b11101, 5'b11111, 5'b11111, 5'b11101};
    do_reset("fault_reset");
    for (int i = 0; i < 11; i++) begin
      step("fault", 1'b1, seq[i]);
      checks++;
      if (b3.fault !== ((i >= 7) ? 5'b00010 : 5'b00000)) begin
        errors++;
        $display("FAIL fault_seq%0d got %b expected %b", i, b3.fault,
                 ((i >= 7) ? 5'b00010 : 5'b00000));
      end
    end
  endtask
`endif

  task automatic test_power_on();
    rst   = 1'b1;
    valid = 1'b0;
    ins   = 5'b0;
    clear_model();
    #1 check_zero("power_on");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_power_on();
    test_reset();
    test_exhaustive();
    test_hold();
    test_saturation();
    test_parameter();
    test_back_to_back();
`ifdef THREE_OF_FIVE_FAULT_EN
    test_fault();
`endif
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/three_of_five_voter.md
Name: three_of_five_voter

Overview:
- Registered 5-input majority voter. The output is 1 when at least THRESHOLD of the inputs in_1..in_5 are 1.
- Used as a redundancy or TMR-style vote stage feeding downstream control logic.
- Also reports the population count, a unanimity flag, a per-input dissent mask and a saturating dissent-event counter.

Parameters:
- THRESHOLD, 3, minimum number of 1s needed to assert out. Legal range 1..5; values outside this range are a fatal elaboration error.
- CNT_W, 16, width of the dissent-event counter.
- FAULT_LIMIT, 4, consecutive dissenting samples before an input's fault bit sets. Used only with the optional feature.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- valid_in, input, 1, the current in_1..in_5 sample is to be voted.
- in_1, in_2, in_3, in_4, in_5, input, 1 each, voter inputs.
- out, output, 1, registered vote result.
- valid_out, output, 1, out and all companion outputs are updated this cycle.
- count, output, 3, registered number of 1s among the five inputs (0..5).
- unanimous, output, 1, count is 0 or 5.
- dissent, output, 5, bit k-1 is set when in_k differs from out.
- dissent_cnt, output, CNT_W, saturating count of valid samples that had any dissent.
- fault, output, 5, sticky per-input fault flags. Present only with the optional feature.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - out=0, valid_out=0, count=0, unanimous=0, dissent=0, dissent_cnt=0, fault=0.
  - All state holds at these values while rst is high.
- Combinational pop-count: pc = in_1+in_2+in_3+in_4+in_5, 3 bits, no overflow possible.
- Vote: vote = (pc >= THRESHOLD).
- Latency 1. At a rising clk edge with valid_in=1:
  - out <= vote, count <= pc.
  - unanimous <= (pc==0 || pc==5).
  - dissent[k-1] <= in_k ^ vote.
  - valid_out <= 1.
- At a rising edge with valid_in=0: valid_out <= 0; out, count, unanimous and dissent hold their previous values.
- dissent_cnt increments by 1 on each valid sample where any dissent bit is set.
  - It saturates at 2^CNT_W-1 and never wraps.
  - Only reset clears it.
- With THRESHOLD=3:
  - 3, 4 or 5 ones give out=1; 0, 1 or 2 ones give out=0.
  - A 3-of-5 tie cannot occur.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect.
- Reset asserted mid-stream clears all outputs immediately. The first valid sample after reset deassertion is voted normally.
- No internal input synchronizers: inputs must be synchronous to clk.

Optional Feature:
- Macro: THREE_OF_FIVE_FAULT_EN.
- Defined:
  - Each input has a consecutive-dissent counter sized to hold FAULT_LIMIT.
  - The counter increments on a valid sample where that input dissents.
  - It clears on a valid sample where the input agrees, and holds on valid_in=0.
  - When the counter reaches FAULT_LIMIT, fault[k-1] sets and stays set until rst.
  - Fault flags do not alter the vote.
- Undefined: no fault port and no per-input counters. All other behaviour is identical.

Test Plan:
- Reset: apply rst=1 mid-operation with out=1 and dissent_cnt=7 → all outputs go to 0 immediately, before the next clk edge.
- Exhaustive vote: all 32 input patterns with valid_in=1, THRESHOLD=3 → out=1 exactly when count>=3; e.g. 10110 gives count=3, out=1, dissent=01001; 10010 gives count=2, out=0.
- Hold: valid_in=0 with 11111 applied after a 00000 vote → valid_out=0 and out/count stay at 0/0. The next valid cycle gives out=1, count=5, unanimous=1.
- Saturation: CNT_W=2 with 5 consecutive dissenting samples → dissent_cnt goes 1, 2, 3, 3, 3. A unanimous sample leaves it unchanged.
- Parameter: THRESHOLD=5 with input 11110 → out=0, dissent=11110. THRESHOLD=1 with input 00001 → out=1.
- Fault (macro defined, FAULT_LIMIT=4): in_2 alone opposes the majority for 3 samples, agrees once, then opposes for 4 more → fault stays 00000 until the 4th consecutive dissent, then becomes 00010 and remains set thereafter.
